// File: rtl/adc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adc_pkg
// Brief    : Shared state encoding, word width and frame-length helper for the
//            serial ADC front end.
// Revision : 1.0
// ============================================================================
package adc_pkg;

  localparam int ADC_BITS = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONV  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } adc_state_e;

  // Busy cycles from the first CONVST-high cycle through the newdata cycle.
  function automatic int adc_frame_len(input int conv_cycles, input int clk_div);
    return conv_cycles + 2 * ADC_BITS * clk_div + 1;
  endfunction

endpackage : adc_pkg
`default_nettype wire

// File: rtl/adc_sclk_gen.sv
`default_nettype none
// ============================================================================
// Module   : adc_sclk_gen
// Brief    : SCLK half-period and bit counter for one 16-bit serial readout.
// Revision : 1.0
// ============================================================================
module adc_sclk_gen #(
  parameter int CLK_DIV = 2,
  parameter int BITS    = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  output logic sclk_o,
  output logic sample_now_o,
  output logic bit_end_o,
  output logic last_bit_o
);

  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (BITS > 1) ? $clog2(BITS) : 1;

  logic          active_q;
  logic          half_q;
  logic [HW-1:0] hcnt_q;
  logic [BW-1:0] bit_q;
  logic          sclk_q;
  logic          sample_q;
  logic          half_end_d;

  assign half_end_d   = active_q && (hcnt_q == HW'(CLK_DIV - 1));
  assign bit_end_o    = half_end_d && half_q;
  // Final cycle of the final bit-period; the FSM leaves SHIFT on this.
  assign last_bit_o   = bit_end_o && (bit_q == BW'(BITS - 1));
  assign sclk_o       = sclk_q;
  assign sample_now_o = sample_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      half_q   <= 1'b0;
      hcnt_q   <= '0;
      bit_q    <= '0;
      sclk_q   <= 1'b0;
      sample_q <= 1'b0;
    end else begin
      sample_q <= 1'b0;
      if (start_i) begin
        active_q <= 1'b1;
        half_q   <= 1'b0;
        hcnt_q   <= '0;
        bit_q    <= '0;
        sclk_q   <= 1'b0;
      end else if (active_q) begin
        if (half_end_d) begin
          hcnt_q   <= '0;
          half_q   <= ~half_q;
          sclk_q   <= ~half_q;
          sample_q <= ~half_q;
          if (half_q) begin
            if (last_bit_o) begin
              active_q <= 1'b0;
            end else begin
              bit_q <= bit_q + BW'(1);
            end
          end
        end else begin
          hcnt_q <= hcnt_q + HW'(1);
        end
      end
    end
  end

endmodule : adc_sclk_gen
`default_nettype wire

// File: rtl/adc_sampler.sv
`default_nettype none
// ============================================================================
// Module   : adc_sampler
// Brief    : Periodic serial-ADC acquisition with newdata strobe and PGA gain.
// Revision : 1.0
// ============================================================================
module adc_sampler
  import adc_pkg::*;
#(
  parameter int CLK_DIV       = 2,
  parameter int CONV_CYCLES   = 24,
  parameter int SAMPLE_PERIOD = 180
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [1:0]          gain,
  input  logic [ADC_BITS-1:0] cfg,
  output logic                CONVST,
  output logic                SCLK,
  output logic                SDI,
  input  logic                SDO,
  output logic                GAIN_A0,
  output logic                GAIN_A1,
  output logic [ADC_BITS-1:0] dout,
  output logic                newdata,
  output logic                busy,
  output logic                overrun
);

  localparam int TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int CW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;

  adc_state_e          state_q;
  logic [TW-1:0]       tmr_q;
  logic [CW-1:0]       conv_cnt_q;
  logic [ADC_BITS-1:0] cfg_q;
  logic [ADC_BITS-1:0] sr_q;
  logic [ADC_BITS-1:0] sr_d;
  logic                tick_d;
  logic                start_d;
  logic                sample_now;
  logic                bit_end;
  logic                last_bit;

  assign tick_d  = (tmr_q == '0);
  assign start_d = (state_q == ST_CONV) && (conv_cnt_q == CW'(CONV_CYCLES - 1));
  // Lets the final SDO bit land in dout even when it is sampled in the last cycle.
  assign sr_d    = sample_now ? {sr_q[ADC_BITS-2:0], SDO} : sr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_q <= TW'(SAMPLE_PERIOD - 1);
    end else if (tick_d) begin
      tmr_q <= TW'(SAMPLE_PERIOD - 1);
    end else begin
      tmr_q <= tmr_q - TW'(1);
    end
  end

  adc_sclk_gen #(
    .CLK_DIV (CLK_DIV),
    .BITS    (ADC_BITS)
  ) u_sclk_gen (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_d),
    .sclk_o       (SCLK),
    .sample_now_o (sample_now),
    .bit_end_o    (bit_end),
    .last_bit_o   (last_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      conv_cnt_q <= '0;
      cfg_q      <= '0;
      sr_q       <= '0;
      CONVST     <= 1'b0;
      SDI        <= 1'b1;
      GAIN_A0    <= 1'b0;
      GAIN_A1    <= 1'b0;
      dout       <= '0;
      newdata    <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      newdata <= 1'b0;
      sr_q    <= sr_d;
      if (tick_d && (state_q != ST_IDLE)) begin
        overrun <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (tick_d && en) begin
            state_q            <= ST_CONV;
            conv_cnt_q         <= '0;
            CONVST             <= 1'b1;
            busy               <= 1'b1;
            {GAIN_A1, GAIN_A0} <= gain;
            cfg_q              <= cfg;
          end
        end
        ST_CONV: begin
          if (start_d) begin
            state_q <= ST_SHIFT;
            CONVST  <= 1'b0;
            SDI     <= cfg_q[ADC_BITS-1];
            cfg_q   <= {cfg_q[ADC_BITS-2:0], 1'b1};
          end else begin
            conv_cnt_q <= conv_cnt_q + CW'(1);
          end
        end
        ST_SHIFT: begin
          if (last_bit) begin
            state_q <= ST_DONE;
            dout    <= sr_d;
            newdata <= 1'b1;
            SDI     <= 1'b1;
          end else if (bit_end) begin
            SDI   <= cfg_q[ADC_BITS-1];
            cfg_q <= {cfg_q[ADC_BITS-2:0], 1'b1};
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : adc_sampler
`default_nettype wire

// File: tb/tb_adc_sampler.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_sampler
// Brief    : Randomized bench; two DUTs (normal and short sample period).
// Revision : 1.0
// ============================================================================
module tb_adc_sampler;

  localparam int CD = 2;
  localparam int CC = 24;
  localparam int FL = CC + 32 * CD + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  gain;
  logic [15:0] cfg;
  logic [1:0]  sdo_q = 2'b00;
  logic [1:0]  sdo_nxt = 2'b00;
  logic [1:0]  convst, sclk, sdi, ga0, ga1, newdata, busy, overrun;
  logic [15:0] dout0, dout1;

  always #5 clk = ~clk;

  adc_sampler #(.CLK_DIV(CD), .CONV_CYCLES(CC), .SAMPLE_PERIOD(180)) u_dut_slow (
    .clk(clk), .rst(rst), .en(en), .gain(gain), .cfg(cfg),
    .CONVST(convst[0]), .SCLK(sclk[0]), .SDI(sdi[0]), .SDO(sdo_q[0]),
    .GAIN_A0(ga0[0]), .GAIN_A1(ga1[0]), .dout(dout0), .newdata(newdata[0]),
    .busy(busy[0]), .overrun(overrun[0])
  );

  adc_sampler #(.CLK_DIV(CD), .CONV_CYCLES(CC), .SAMPLE_PERIOD(60)) u_dut_fast (
    .clk(clk), .rst(rst), .en(en), .gain(gain), .cfg(cfg),
    .CONVST(convst[1]), .SCLK(sclk[1]), .SDI(sdi[1]), .SDO(sdo_q[1]),
    .GAIN_A0(ga0[1]), .GAIN_A1(ga1[1]), .dout(dout1), .newdata(newdata[1]),
    .busy(busy[1]), .overrun(overrun[1])
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input int d, input logic [15:0] got,
                          input logic [15:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s dut=%0d t=%0t got=%h exp=%h", tag, d, $time, got, exp);
    end
  endtask

  // Reference model: each frame is described only by its tick cycle.
  int          cyc   = 0;
  bit          valid = 1'b0;
  bit          has[2];
  int          fst[2];
  int          nfr[2];
  bit          ovr[2];
  logic [15:0] word[2];
  logic [15:0] cfgl[2];
  logic [15:0] dout_e[2];
  logic [1:0]  gl[2];

  function automatic int sp_of(input int d);
    return (d == 0) ? 180 : 60;
  endfunction

  always @(negedge clk) begin
    bit   act;
    int   k, j, sp;
    logic e_cs, e_sck, e_sdi, e_nd;
    if (valid) begin
      for (int d = 0; d < 2; d++) begin
        act = has[d] && (cyc >= fst[d] + 1) && (cyc <= fst[d] + FL);
        k   = cyc - fst[d] - 1;
        if (act && k == FL - 1) dout_e[d] = word[d];
        e_cs  = act && (k < CC);
        e_sck = 1'b0;
        e_sdi = 1'b1;
        if (act && k >= CC && k < CC + 32 * CD) begin
          j     = k - CC;
          e_sck = (j % (2 * CD)) >= CD;
          e_sdi = cfgl[d][15 - j / (2 * CD)];
        end
        e_nd = act && (k == FL - 1);
        check_eq("convst",  d, 16'(convst[d]),  16'(e_cs));
        check_eq("sclk",    d, 16'(sclk[d]),    16'(e_sck));
        check_eq("sdi",     d, 16'(sdi[d]),     16'(e_sdi));
        check_eq("newdata", d, 16'(newdata[d]), 16'(e_nd));
        check_eq("busy",    d, 16'(busy[d]),    16'(act));
        check_eq("overrun", d, 16'(overrun[d]), 16'(ovr[d]));
        check_eq("gain",    d, 16'({ga1[d], ga0[d]}), 16'(gl[d]));
        check_eq("dout",    d, (d == 0) ? dout0 : dout1, dout_e[d]);
      end
    end
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        has[d] = 1'b0; ovr[d] = 1'b0; dout_e[d] = '0; gl[d] = '0; fst[d] = 0;
      end
      cyc   = 0;
      valid = 1'b1;
    end else if (valid) begin
      for (int d = 0; d < 2; d++) begin
        sp = sp_of(d);
        if ((cyc % sp) == sp - 1) begin
          if (has[d] && cyc >= fst[d] + 1 && cyc <= fst[d] + FL) begin
            ovr[d] = 1'b1;
          end else if (en) begin
            has[d]  = 1'b1;
            fst[d]  = cyc;
            cfgl[d] = cfg;
            gl[d]   = gain;
            word[d] = (nfr[d] == 0) ? 16'hA5C3 : 16'($urandom);
            nfr[d]++;
          end
        end
      end
      cyc++;
    end
    // SDO carries the frame bit only while SCLK is high; noise otherwise.
    for (int d = 0; d < 2; d++) begin
      k = cyc - fst[d] - 1 - CC;
      sdo_nxt[d] = 1'($urandom);
      if (has[d] && k >= 0 && k < 32 * CD && (k % (2 * CD)) >= CD)
        sdo_nxt[d] = word[d][15 - k / (2 * CD)];
    end
  end

  always @(posedge clk) sdo_q <= sdo_nxt;

  task automatic run_cycles(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (rnd) begin
        gain = 2'($urandom);
        cfg  = 16'($urandom);
      end
    end
  endtask

  initial begin
    bit found;
    nfr[0] = 0; nfr[1] = 0;
    rst = 1'b1; en = 1'b0; gain = 2'b00; cfg = 16'h8001;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; en = 1'b1;

    // First frame: fixed cfg/word; gain raised while DUT0 is in SHIFT.
    run_cycles(230, 1'b0);
    gain = 2'b11;
    run_cycles(250, 1'b0);

    // Random gain/cfg every cycle, occasional en toggles.
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk);
      #1;
      gain = 2'($urandom);
      cfg  = 16'($urandom);
      if ($urandom_range(0, 99) < 2) en = ~en;
    end

    // Drop en during CONV.
    en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(posedge clk);
      #1;
      if (has[0] && cyc == fst[0] + 3) begin
        en = 1'b0;
        found = 1'b1;
      end
    end
    check_eq("wait_conv", 0, 16'(found), 16'd1);
    run_cycles(500, 1'b1);

    // Reset on the 8th SCLK rising edge of DUT0.
    en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(posedge clk);
      #1;
      if (has[0] && cyc == fst[0] + 1 + CC + 7 * 2 * CD + CD) begin
        rst = 1'b1;
        found = 1'b1;
      end
    end
    check_eq("wait_rise8", 0, 16'(found), 16'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    run_cycles(600, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_adc_sampler
`default_nettype wire

// File: doc/adc_sampler.md
# adc_sampler

Front-end acquisition stage for the lock-in: drives the 16-bit serial ADC (CONVST/SCLK/SDO/SDI) at a fixed sample rate and presents each conversion as a 16-bit word with a one-cycle `newdata` strobe. It sits directly upstream of the capture logic that writes samples into the 16x16 SRAM, and supplies the `adcen`/`newdata`/`adcdata` handshake that the capture logic consumes. The PGA gain pins are driven from this block, so gain changes never occur mid-conversion.

## Interface
- `CLK_DIV`, 2: clk cycles per SCLK half-period (≥1).
- `CONV_CYCLES`, 24: clk cycles CONVST is held high, covering ADC conversion time (≥1).
- `SAMPLE_PERIOD`, 180: clk cycles between conversion ticks (200 kHz at 36 MHz).
- `clk` in 1: system clock; the only clock.
- `rst` in 1: reset; synchronous, active-high.
- `en` in 1: when high, conversions start on sample ticks (`adcen` from top).
- `gain` in 2: PGA gain request {A1,A0}.
- `cfg` in 16: word shifted to ADC SDI, MSB first, during each readout.
- `CONVST` out 1: ADC conversion start.
- `SCLK` out 1: ADC serial clock; idles low.
- `SDI` out 1: ADC config data; idles high.
- `SDO` in 1: ADC data, MSB first, valid at SCLK rising edge.
- `GAIN_A0`, `GAIN_A1` out 1: PGA gain select.
- `dout` out 16: last completed sample.
- `newdata` out 1: one-cycle strobe; `dout` is valid in the same cycle.
- `busy` out 1: high whenever the FSM is not IDLE.
- `overrun` out 1: sticky; a sample tick arrived while busy.

## Operation
- All outputs are registered. Reset values: `CONVST`=0, `SCLK`=0, `SDI`=1, `GAIN_A*`=0, `dout`=0, `newdata`=0, `busy`=0, `overrun`=0. The tick timer reloads to `SAMPLE_PERIOD-1`.
- The tick timer free-runs from reset regardless of `en`. It counts down and emits `tick` at 0, then reloads.
- FSM states: IDLE → CONV → SHIFT → DONE → IDLE.
- IDLE: on `tick && en`, go to CONV. On entry to CONV, latch `gain` onto `GAIN_A1/A0` and latch `cfg` into the SDI shift register. Otherwise hold.
- CONV: `CONVST`=1 for exactly `CONV_CYCLES` cycles, then go to SHIFT with `CONVST`=0.
- SHIFT: 16 bit-periods. Each bit-period is `SCLK` low for `CLK_DIV` cycles, then high for `CLK_DIV` cycles.
  - `SDI` presents cfg[15-k] throughout bit-period k.
  - `SDO` is sampled into the shift register (MSB first) in the cycle in which `SCLK` is registered high, i.e. at the rising edge.
- DONE: one cycle. `dout` ← shift register, `newdata`=1, `SCLK`=0, `SDI`=1. Then return to IDLE.
- `tick` while not IDLE, or while in IDLE with the FSM not yet able to accept it: the tick is dropped and `overrun` is set. `overrun` clears only on `rst`.
- `en` deasserted mid-frame: the current frame completes normally, including `newdata`; no further frames start.
- `rst` mid-frame: return to IDLE immediately with reset values. No `newdata` for the aborted frame.
- `gain` and `cfg` changes outside IDLE→CONV entry have no effect until the next frame.
- `SAMPLE_PERIOD` below the frame length (`CONV_CYCLES + 32*CLK_DIV + 1`) gives every other tick dropped, with `overrun` set. This is legal but flagged.

## Timing
- Tick in cycle t (IDLE, `en`=1): `CONVST` rises at t+1 and falls at t+1+`CONV_CYCLES`.
- First SCLK rising edge occurs at t+1+`CONV_CYCLES`+`CLK_DIV`.
- `newdata` fires at t+1+`CONV_CYCLES`+32·`CLK_DIV`. With defaults: t+89.
- Frame length with defaults is 89 cycles, giving 91 cycles of IDLE margin per 180-cycle period.
- `newdata` is never high in two consecutive cycles. `busy` falls in the cycle after `newdata`.

## Structure
- Shared package `adc_pkg`:
  - state encoding (IDLE/CONV/SHIFT/DONE, 2 bits);
  - `ADC_BITS`=16;
  - the frame-length expression as a constant function, for reuse by the capture logic's holdoff checks.
- One sub-module, `adc_sclk_gen`: the CLK_DIV half-period counter and bit counter. It outputs `SCLK`, a `sample_now` pulse at the rising edge, and `last_bit`. The FSM and tick timer stay in `adc_sampler`.

## Test plan
- Reset then `en`=1, SDO model returning 16'hA5C3: at the first tick `CONVST` is high for 24 cycles and SCLK shows 16 pulses of 4 clk each. `newdata` fires 89 cycles after the tick with `dout`=16'hA5C3.
- `cfg`=16'h8001: SDI is 1 for bit-period 0, 0 for bits 1–14, 1 for bit 15, and idles at 1.
- `gain` changes from 2'b00 to 2'b11 mid-SHIFT: `GAIN_A*` stays 00 until the next CONV entry, then becomes 11.
- `SAMPLE_PERIOD`=60 (less than 89): `newdata` arrives every 120 cycles and `overrun`=1 after the second tick.
- `rst` asserted on the 8th SCLK rising edge: the next cycle shows all outputs at reset values and no `newdata`. The next frame starts `SAMPLE_PERIOD` cycles after `rst` falls.
- `en` dropped during CONV: that frame still produces `newdata`, with no further CONVST pulses.
